// File: rtl/pll_reset_seq_pkg.sv
// ---------------------------------------------------------------------------
// pll_reset_seq_pkg
// Shared definitions for the PLL reset sequencer: the debug state encoding,
// default cycle counts for each sequencing phase, and a saturating 8-bit
// increment used by the event counters.
// ---------------------------------------------------------------------------
package pll_reset_seq_pkg;

    // Debug-visible state encoding, exported on the 'state' port.
    typedef enum logic [1:0] {
        ST_RST    = 2'b00,
        ST_WAIT   = 2'b01,
        ST_STABLE = 2'b10,
        ST_RUN    = 2'b11
    } state_e;

    // Default phase lengths in clk cycles, and the shared counter width
    // (wide enough for the largest default).
    localparam int unsigned DEF_RESET_CYCLES  = 16;
    localparam int unsigned DEF_LOCK_TIMEOUT  = 65535;
    localparam int unsigned DEF_STABLE_CYCLES = 1024;
    localparam int unsigned DEF_CNT_W         = 16;

    // Event counters stick at all-ones instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer bringing an asynchronous level into the clk domain.
// Both flops clear to 0 on reset so a "true" level is never reported until it
// has been seen on two consecutive edges.
//
// Ports:
//   clk   - destination clock
//   rst_n - asynchronous active-low reset, clears both flops
//   d     - asynchronous input level
//   q     - synchronized level, two clk cycles behind d
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Plain shift: the first stage may go metastable, the second resolves it.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
// Sequences a PLL out of reset and releases downstream logic only after the
// PLL has reported stable lock.  Phases:
//   RST    - hold the PLL in reset for RESET_CYCLES cycles
//   WAIT   - PLL running, wait for lock; retry from RST after LOCK_TIMEOUT
//   STABLE - lock must hold for STABLE_CYCLES consecutive cycles
//   RUN    - downstream reset released; any lock loss restarts from RST
// One phase counter is shared by RST, WAIT and STABLE.
//
// Ports:
//   clk           - reference clock (PLL input clock), only clock domain
//   resetn        - asynchronous active-low reset
//   locked        - PLL lock indicator, asynchronous to clk
//   pll_resetb    - PLL RESETB pin drive, 0 holds the PLL in reset
//   sys_resetn    - downstream active-low reset, 1 means released
//   ready         - high while in RUN
//   state         - debug state encoding (RST=00 WAIT=01 STABLE=10 RUN=11)
//   lost_count    - lock losses seen in RUN, saturating at 255
//   timeout_count - WAIT timeouts, saturating at 255
// ---------------------------------------------------------------------------
module pll_reset_seq
    import pll_reset_seq_pkg::*;
#(
    parameter int unsigned RESET_CYCLES  = DEF_RESET_CYCLES,
    parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int unsigned CNT_W         = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       locked,
    output logic       pll_resetb,
    output logic       sys_resetn,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] lost_count,
    output logic [7:0] timeout_count
);

    // Terminal counts for each phase, in the counter's own width.
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    logic             lock_s;

    state_e           state_q;
    state_e           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [7:0]       lost_count_q;
    logic [7:0]       lost_count_d;
    logic [7:0]       timeout_count_q;
    logic [7:0]       timeout_count_d;
    logic             pll_resetb_q;
    logic             pll_resetb_d;
    logic             sys_resetn_q;
    logic             sys_resetn_d;
    logic             ready_q;
    logic             ready_d;

    // The only place 'locked' is sampled.
    sync_2ff u_lock_sync (
        .clk   (clk),
        .rst_n (resetn),
        .d     (locked),
        .q     (lock_s)
    );

    // State, counters and output registers.  Outputs are registered from the
    // next-state decode so they switch on the same edge as the state does.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_RST;
            cnt_q           <= '0;
            lost_count_q    <= 8'd0;
            timeout_count_q <= 8'd0;
            pll_resetb_q    <= 1'b0;
            sys_resetn_q    <= 1'b0;
            ready_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            lost_count_q    <= lost_count_d;
            timeout_count_q <= timeout_count_d;
            pll_resetb_q    <= pll_resetb_d;
            sys_resetn_q    <= sys_resetn_d;
            ready_q         <= ready_d;
        end
    end

    // Next-state and counter logic.  Every transition clears the shared
    // counter so each phase starts counting from zero.  In WAIT a lock seen
    // on the timeout cycle takes priority, so no timeout is recorded.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        lost_count_d    = lost_count_q;
        timeout_count_d = timeout_count_q;

        case (state_q)
            ST_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_WAIT: begin
                if (lock_s) begin
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d         = ST_RST;
                    cnt_d           = '0;
                    timeout_count_d = sat_inc8(timeout_count_q);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_STABLE: begin
                if (!lock_s) begin
                    state_d = ST_WAIT;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ST_RUN: begin
                cnt_d = '0;
                if (!lock_s) begin
                    state_d      = ST_RST;
                    lost_count_d = sat_inc8(lost_count_q);
                end
            end
            default: begin
                state_d = ST_RST;
                cnt_d   = '0;
            end
        endcase
    end

    // Output decode from the next state.
    always_comb begin
        pll_resetb_d = (state_d != ST_RST);
        sys_resetn_d = (state_d == ST_RUN);
        ready_d      = (state_d == ST_RUN);
    end

    assign pll_resetb    = pll_resetb_q;
    assign sys_resetn    = sys_resetn_q;
    assign ready         = ready_q;
    assign state         = state_q;
    assign lost_count    = lost_count_q;
    assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
// Self-checking bench for pll_reset_seq with RESET_CYCLES=4, LOCK_TIMEOUT=32,
// STABLE_CYCLES=8.  Each scenario task pushes expected output snapshots
// {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count}, tagged
// with the clk edge number after which they must hold, and pops/compares them
// at the following falling edge.  Latencies count the edge that first samples
// a new 'locked' level as edge 1, so a lock drop in RUN lands on the third
// edge and a release lands on edge STABLE_CYCLES+3.
// ---------------------------------------------------------------------------
module tb_pll_reset_seq;

    localparam int RC = 4;
    localparam int LT = 32;
    localparam int SC = 8;

    // {pll_resetb, sys_resetn, ready, state}
    localparam logic [4:0] O_RST    = 5'b0_0_0_00;
    localparam logic [4:0] O_WAIT   = 5'b1_0_0_01;
    localparam logic [4:0] O_STABLE = 5'b1_0_0_10;
    localparam logic [4:0] O_RUN    = 5'b1_1_1_11;

    logic       clk = 1'b0;
    logic       resetn;
    logic       locked;
    logic       pll_resetb;
    logic       sys_resetn;
    logic       ready;
    logic [1:0] state;
    logic [7:0] lost_count;
    logic [7:0] timeout_count;

    int cyc_cnt  = 0;
    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        int          cyc;
        logic [20:0] vec;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    pll_reset_seq #(
        .RESET_CYCLES  (RC),
        .LOCK_TIMEOUT  (LT),
        .STABLE_CYCLES (SC)
    ) dut (
        .clk           (clk),
        .resetn        (resetn),
        .locked        (locked),
        .pll_resetb    (pll_resetb),
        .sys_resetn    (sys_resetn),
        .ready         (ready),
        .state         (state),
        .lost_count    (lost_count),
        .timeout_count (timeout_count)
    );

    function automatic void push(input int c, input logic [4:0] o, input logic [7:0] l,
                                 input logic [7:0] t, input string tag);
        exp_t e;
        e.cyc = c;
        e.vec = {o, l, t};
        e.tag = tag;
        exp_q.push_back(e);
    endfunction

    // Reset state, both asynchronously and while clocks run.
    task automatic test_reset();
        logic [4:0] obs;
        resetn = 1'b1;
        locked = 1'b0;
        #2 resetn = 1'b0;
        #1;
        obs = {pll_resetb, sys_resetn, ready, state};
        n_checks++;
        if (obs !== O_RST) begin
            n_fail++;
            $display("[TB] FAIL reset_async_outs: observed %b, expected %b", obs, O_RST);
        end
        repeat (3) @(negedge clk);
        obs = {pll_resetb, sys_resetn, ready, state};
        n_checks++;
        if (obs !== O_RST) begin
            n_fail++;
            $display("[TB] FAIL reset_held_outs: observed %b, expected %b", obs, O_RST);
        end
        n_checks++;
        if ({lost_count, timeout_count} !== 16'h0000) begin
            n_fail++;
            $display("[TB] FAIL reset_counters: observed %h, expected 0000",
                     {lost_count, timeout_count});
        end
    endtask

    // Scenario 1: release, lock arrives 10 cycles later.
    task automatic test_normal_release();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        @(negedge clk);
        resetn = 1'b1;
        base   = cyc_cnt;
        push(base + 1, O_RST,  8'd0, 8'd0, "rst_edge1");
        push(base + 3, O_RST,  8'd0, 8'd0, "rst_edge3");
        push(base + 4, O_WAIT, 8'd0, 8'd0, "rst_exit_edge4");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
        end
        locked = 1'b1;
        base   = cyc_cnt;
        push(base + 2,  O_WAIT,   8'd0, 8'd0, "sync_latency");
        push(base + 3,  O_STABLE, 8'd0, 8'd0, "stable_enter");
        push(base + 10, O_STABLE, 8'd0, 8'd0, "stable_before_release");
        push(base + 11, O_RUN,    8'd0, 8'd0, "release");
        push(base + 13, O_RUN,    8'd0, 8'd0, "run_hold");
        for (int k = 0; k < 13; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
        end
    endtask

    // Scenario 2: no lock, three timeout retries 36 cycles apart.
    task automatic test_timeout();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        @(negedge clk);
        locked = 1'b0;
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        base   = cyc_cnt;
        push(base + 3, O_RST,  8'd0, 8'd0, "tmo_first_low");
        push(base + 4, O_WAIT, 8'd0, 8'd0, "tmo_first_wait");
        for (int p = 1; p <= 3; p++) begin
            push(base + 36 * p - 1, O_WAIT, 8'd0, 8'(p - 1), "tmo_wait_last");
            push(base + 36 * p,     O_RST,  8'd0, 8'(p),     "tmo_retry_low");
            push(base + 36 * p + 3, O_RST,  8'd0, 8'(p),     "tmo_retry_low_end");
            push(base + 36 * p + 4, O_WAIT, 8'd0, 8'(p),     "tmo_retry_wait");
        end
        for (int k = 0; k < 36 * 3 + 4; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
        end
    endtask

    // Scenario 3: two-cycle lock glitch while STABLE.
    task automatic test_glitch_stable();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        locked = 1'b1;
        base   = cyc_cnt;
        push(base + 3,  O_STABLE, 8'd0, 8'd3, "glitch_stable_enter");
        push(base + 7,  O_STABLE, 8'd0, 8'd3, "glitch_not_yet_seen");
        push(base + 8,  O_WAIT,   8'd0, 8'd3, "glitch_back_to_wait");
        push(base + 9,  O_WAIT,   8'd0, 8'd3, "glitch_wait_hold");
        push(base + 10, O_STABLE, 8'd0, 8'd3, "glitch_restable");
        push(base + 17, O_STABLE, 8'd0, 8'd3, "glitch_before_release");
        push(base + 18, O_RUN,    8'd0, 8'd3, "glitch_release");
        for (int k = 0; k < 19; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
            if (k == 4) locked = 1'b0;
            if (k == 6) locked = 1'b1;
        end
    endtask

    // Scenario 4: lock lost in RUN, then the full sequence resumes.
    task automatic test_lock_loss_run();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        locked = 1'b0;
        base   = cyc_cnt;
        push(base + 2,  O_RUN,    8'd0, 8'd3, "loss_not_yet_seen");
        push(base + 3,  O_RST,    8'd1, 8'd3, "loss_drop");
        push(base + 6,  O_RST,    8'd1, 8'd3, "loss_pll_low_end");
        push(base + 7,  O_WAIT,   8'd1, 8'd3, "loss_pll_release");
        push(base + 11, O_WAIT,   8'd1, 8'd3, "loss_wait_sync");
        push(base + 12, O_STABLE, 8'd1, 8'd3, "loss_stable");
        push(base + 19, O_STABLE, 8'd1, 8'd3, "loss_before_release");
        push(base + 20, O_RUN,    8'd1, 8'd3, "loss_rerelease");
        for (int k = 0; k < 21; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
            if (k == 8) locked = 1'b1;
        end
    endtask

    // Scenario 5: 260 further lock losses, lost_count must stick at 255.
    task automatic test_saturation();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        logic [7:0]  exp_lost;
        exp_lost = 8'd1;
        for (int n = 0; n < 260; n++) begin
            locked = 1'b0;
            base   = cyc_cnt;
            exp_lost = (exp_lost == 8'd255) ? 8'd255 : exp_lost + 8'd1;
            push(base + 3,  O_RST, exp_lost, 8'd3, "sat_drop");
            push(base + 16, O_RUN, exp_lost, 8'd3, "sat_run");
            for (int k = 0; k < 17; k++) begin
                @(negedge clk);
                while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                    e   = exp_q.pop_front();
                    obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                    n_checks++;
                    if (obs !== e.vec || e.cyc != cyc_cnt) begin
                        n_fail++;
                        $display("[TB] FAIL %s #%0d (cyc %0d): observed %b, expected %b", e.tag, n, cyc_cnt, obs, e.vec);
                    end
                end
                if (k == 1) locked = 1'b1;
            end
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (lost_count !== 8'd255) begin
            n_fail++;
            $display("[TB] FAIL sat_hold: observed lost_count %0d, expected 255", lost_count);
        end
    endtask

    // Scenario 6: asynchronous reset between edges while in RUN, then a
    // complete restart with lock already present.
    task automatic test_reset_mid_run();
        exp_t        e;
        logic [20:0] obs;
        int          base;
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
        n_checks++;
        if (obs !== {O_RST, 8'd0, 8'd0}) begin
            n_fail++;
            $display("[TB] FAIL midrun_async_reset: observed %b, expected %b", obs, {O_RST, 16'd0});
        end
        @(negedge clk);
        resetn = 1'b1;
        base   = cyc_cnt;
        push(base + 1,  O_RST,    8'd0, 8'd0, "restart_edge1");
        push(base + 3,  O_RST,    8'd0, 8'd0, "restart_full_count");
        push(base + 4,  O_WAIT,   8'd0, 8'd0, "restart_wait");
        push(base + 5,  O_STABLE, 8'd0, 8'd0, "restart_stable");
        push(base + 12, O_STABLE, 8'd0, 8'd0, "restart_before_release");
        push(base + 13, O_RUN,    8'd0, 8'd0, "restart_release");
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            while (exp_q.size() != 0 && exp_q[0].cyc <= cyc_cnt) begin
                e   = exp_q.pop_front();
                obs = {pll_resetb, sys_resetn, ready, state, lost_count, timeout_count};
                n_checks++;
                if (obs !== e.vec || e.cyc != cyc_cnt) begin
                    n_fail++;
                    $display("[TB] FAIL %s (cyc %0d): observed %b, expected %b", e.tag, cyc_cnt, obs, e.vec);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_normal_release();
        test_timeout();
        test_glitch_stable();
        test_lock_loss_run();
        test_saturation();
        test_reset_mid_run();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drained: observed %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
